// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the RISC-V pipeline hazard logic: hazard FSM states and
// forwarding operand selects.
package riscv_pipe_pkg;

   typedef enum logic [1:0] {
      HZ_RUN     = 2'd0,
      HZ_MC_WAIT = 2'd1,
      HZ_FLUSH   = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/forwarding_unit.sv
// EX operand forwarding comparators: picks EX/MEM over MEM/WB, never forwards x0,
// and is silenced by the hazard controller while EX is frozen.
module forwarding_unit
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned reg_addr_width = 5,
   parameter int unsigned forward_enable = 1
) (
   input  logic [reg_addr_width-1:0] ex_rs1,
   input  logic [reg_addr_width-1:0] ex_rs2,
   input  logic [reg_addr_width-1:0] mem_rd,
   input  logic                      mem_reg_write,
   input  logic [reg_addr_width-1:0] wb_rd,
   input  logic                      wb_reg_write,
   input  logic                      block,
   output logic [1:0]                forward_a,
   output logic [1:0]                forward_b
);

   function automatic logic [1:0] fwd_sel(
      input logic [reg_addr_width-1:0] rs,
      input logic [reg_addr_width-1:0] m_rd,
      input logic                      m_we,
      input logic [reg_addr_width-1:0] w_rd,
      input logic                      w_we
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (m_we && (m_rd != '0) && (m_rd == rs)) begin
         sel = FWD_EXMEM;
      end else if (w_we && (w_rd != '0) && (w_rd == rs)) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

   always_comb begin
      forward_a = FWD_RF;
      forward_b = FWD_RF;
      if ((forward_enable != 0) && !block) begin
         forward_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
         forward_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush/forward controller: branch flush sequencing, load-use and
// no-forward RAW stalls, and multi-cycle EX wait with a sticky timeout flag.
module hazard_control_unit
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned reg_addr_width = 5,
   parameter int unsigned branch_penalty = 2,
   parameter int unsigned forward_enable = 1,
   parameter int unsigned mc_max_cycles  = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [reg_addr_width-1:0] id_rs1,
   input  logic [reg_addr_width-1:0] id_rs2,
   input  logic                      id_uses_rs1,
   input  logic                      id_uses_rs2,
   input  logic [reg_addr_width-1:0] ex_rs1,
   input  logic [reg_addr_width-1:0] ex_rs2,
   input  logic [reg_addr_width-1:0] ex_rd,
   input  logic                      ex_reg_write,
   input  logic                      ex_mem_read,
   input  logic [reg_addr_width-1:0] mem_rd,
   input  logic                      mem_reg_write,
   input  logic [reg_addr_width-1:0] wb_rd,
   input  logic                      wb_reg_write,
   input  logic                      ex_branch_taken,
   input  logic                      mc_start,
   input  logic                      mc_done,
   output logic                      stall,
   output logic                      bubble,
   output logic                      ex_hold,
   output logic                      flush_if_id,
   output logic                      flush_id_ex,
   output logic [1:0]                forward_a,
   output logic [1:0]                forward_b,
   output logic                      mc_timeout,
   output logic [1:0]                hz_state
);

   localparam int unsigned MCNT_W = $clog2(mc_max_cycles + 1);
   localparam int unsigned FCNT_W = 3;
   localparam logic [MCNT_W-1:0] MC_MAX = MCNT_W'(mc_max_cycles);

   hz_state_t         state_q, state_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              mc_timeout_q, mc_timeout_d;

   logic load_use, ex_raw, mem_raw, raw_stall, fwd_block;

   // ID source matches against younger-stage destinations; x0 never matches
   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
      ex_raw   = ex_reg_write && (ex_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
      mem_raw  = mem_reg_write && (mem_rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == mem_rd)) || (id_uses_rs2 && (id_rs2 == mem_rd)));
      raw_stall = (forward_enable == 0) && (ex_raw || mem_raw);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= HZ_RUN;
         mcnt_q       <= '0;
         fcnt_q       <= '0;
         mc_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mcnt_q       <= mcnt_d;
         fcnt_q       <= fcnt_d;
         mc_timeout_q <= mc_timeout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mcnt_d       = mcnt_q;
      fcnt_d       = fcnt_q;
      mc_timeout_d = mc_timeout_q;
      case (state_q)
         HZ_RUN: begin
            if (ex_branch_taken) begin
               if (branch_penalty > 2) begin
                  state_d = HZ_FLUSH;
                  fcnt_d  = FCNT_W'(branch_penalty - 2);
               end
            end else if (mc_start && !mc_done) begin
               state_d = HZ_MC_WAIT;
               mcnt_d  = MCNT_W'(1);
            end
         end
         HZ_MC_WAIT: begin
            if (mc_done) begin
               state_d = HZ_RUN;
            end else if (mcnt_q >= MC_MAX) begin
               state_d      = HZ_RUN;
               mc_timeout_d = 1'b1;
            end else begin
               mcnt_d = mcnt_q + MCNT_W'(1);
            end
         end
         HZ_FLUSH: begin
            fcnt_d = fcnt_q - FCNT_W'(1);
            if (fcnt_q <= FCNT_W'(1)) begin
               state_d = HZ_RUN;
            end
         end
         default: state_d = HZ_RUN;
      endcase
   end

   // Outputs are combinational and held at zero throughout reset
   always_comb begin
      stall       = 1'b0;
      bubble      = 1'b0;
      ex_hold     = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      mc_timeout  = 1'b0;
      hz_state    = 2'd0;
      if (!reset) begin
         mc_timeout = mc_timeout_q;
         hz_state   = state_q;
         case (state_q)
            HZ_RUN: begin
               if (ex_branch_taken) begin
                  flush_if_id = 1'b1;
                  flush_id_ex = 1'b1;
               end else if (mc_start && !mc_done) begin
                  stall   = 1'b1;
                  ex_hold = 1'b1;
               end else if (load_use || raw_stall) begin
                  stall  = 1'b1;
                  bubble = 1'b1;
               end
            end
            HZ_MC_WAIT: begin
               if (!mc_done && (mcnt_q < MC_MAX)) begin
                  stall   = 1'b1;
                  ex_hold = 1'b1;
               end
            end
            HZ_FLUSH: flush_if_id = 1'b1;
            default: ;
         endcase
      end
   end

   assign fwd_block = reset || (ex_hold && !mc_done);

   forwarding_unit #(
      .reg_addr_width (reg_addr_width),
      .forward_enable (forward_enable)
   ) u_fwd (
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .block         (fwd_block),
      .forward_a     (forward_a),
      .forward_b     (forward_b)
   );

endmodule
